// File: rtl/mult_div_pkg.sv
// Shared opcode encoding, controller state encoding and watchdog default
// for the multiply/divide sequencing controller.
package mult_div_pkg;

    localparam int TIMEOUT_DEFAULT = 40;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } opcode_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_MULT_START = 3'd1;
    localparam state_t ST_MULT_WAIT  = 3'd2;
    localparam state_t ST_DIV_START  = 3'd3;
    localparam state_t ST_DIV_WAIT   = 3'd4;
    localparam state_t ST_WRITE      = 3'd5;

endpackage

// File: rtl/unit_watchdog.sv
// Cycle counter guarding a WAIT state; expired marks the TIMEOUT-th enabled
// cycle since the last clear.
module unit_watchdog #(
    parameter int TIMEOUT = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    // count_reg holds the number of enabled cycles already completed.
    assign expired = enable && (count_reg == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequencer for the iterative multiply/divide units; owns HI/LO, drives the
// pipeline stall and aborts an operation whose unit never reports done.
module mult_div_ctrl
    import mult_div_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             OpStart,
    input  logic [1:0]       OpCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OperandA,
    output logic [WIDTH-1:0] OperandB,
    output logic             MultIn,
    input  logic             MultOut,
    input  logic [WIDTH-1:0] MultHi,
    input  logic [WIDTH-1:0] MultLo,
    output logic             DivIn,
    input  logic             DivOut,
    input  logic [WIDTH-1:0] DivHi,
    input  logic [WIDTH-1:0] DivLo,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             DivZero,
    output logic             Timeout
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] hi_reg, lo_reg;
    logic [WIDTH-1:0] opa_reg, opb_reg;
    logic [WIDTH-1:0] res_hi_reg, res_lo_reg;
    logic             div_zero_reg, div_zero_next;
    logic             timeout_reg, timeout_next;
    logic             load_ops, capture_mult, capture_div;
    logic             write_hi, write_lo;
    logic             wd_clear, wd_enable, wd_expired;
    opcode_e          op;

    assign op = opcode_e'(OpCode);

    always_comb begin
        state_next    = state_reg;
        load_ops      = 1'b0;
        capture_mult  = 1'b0;
        capture_div   = 1'b0;
        write_hi      = 1'b0;
        write_lo      = 1'b0;
        div_zero_next = 1'b0;
        timeout_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (OpStart) begin
                    case (op)
                        OP_MULT: begin
                            load_ops   = 1'b1;
                            state_next = ST_MULT_START;
                        end
                        OP_DIV: begin
                            if (B == '0) begin
                                div_zero_next = 1'b1;
                            end else begin
                                load_ops   = 1'b1;
                                state_next = ST_DIV_START;
                            end
                        end
                        OP_MTHI: write_hi = 1'b1;
                        OP_MTLO: write_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            // The done flag is still high from the previous operation here.
            ST_MULT_START: state_next = ST_MULT_WAIT;
            ST_DIV_START:  state_next = ST_DIV_WAIT;
            ST_MULT_WAIT: begin
                if (MultOut) begin
                    capture_mult = 1'b1;
                    state_next   = ST_WRITE;
                end else if (wd_expired) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_DIV_WAIT: begin
                if (DivOut) begin
                    capture_div = 1'b1;
                    state_next  = ST_WRITE;
                end else if (wd_expired) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end
            end
            ST_WRITE: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign wd_clear  = (state_reg == ST_MULT_START) || (state_reg == ST_DIV_START);
    assign wd_enable = (state_reg == ST_MULT_WAIT) || (state_reg == ST_DIV_WAIT);

    unit_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (Reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_reg    <= ST_IDLE;
            hi_reg       <= '0;
            lo_reg       <= '0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            res_hi_reg   <= '0;
            res_lo_reg   <= '0;
            div_zero_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_zero_reg <= div_zero_next;
            timeout_reg  <= timeout_next;
            if (load_ops) begin
                opa_reg <= A;
                opb_reg <= B;
            end
            // The result is staged so HI/LO only move at the end of WRITE.
            if (capture_mult) begin
                res_hi_reg <= MultHi;
                res_lo_reg <= MultLo;
            end else if (capture_div) begin
                res_hi_reg <= DivHi;
                res_lo_reg <= DivLo;
            end
            if (write_hi) begin
                hi_reg <= A;
            end else if (state_reg == ST_WRITE) begin
                hi_reg <= res_hi_reg;
            end
            if (write_lo) begin
                lo_reg <= A;
            end else if (state_reg == ST_WRITE) begin
                lo_reg <= res_lo_reg;
            end
        end
    end

    assign OperandA = opa_reg;
    assign OperandB = opb_reg;
    assign Hi       = hi_reg;
    assign Lo       = lo_reg;
    assign MultIn   = (state_reg == ST_MULT_START);
    assign DivIn    = (state_reg == ST_DIV_START);
    assign Busy     = (state_reg != ST_IDLE);
    assign DivZero  = div_zero_reg;
    assign Timeout  = timeout_reg;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed and randomized checks of mult_div_ctrl against a transaction-level
// model driven by behavioural multiply/divide units with configurable latency.
module tb_mult_div_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        Reset = 1'b0;
    logic        OpStart = 1'b0;
    logic [1:0]  OpCode = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic [31:0] OperandA, OperandB, Hi, Lo;
    logic        MultIn, DivIn, Busy, DivZero, Timeout;
    logic        MultOut = 1'b0, DivOut = 1'b0;
    logic [31:0] MultHi = '0, MultLo = '0, DivHi = '0, DivLo = '0;

    int vectors = 0;
    int miscompares = 0;
    int unit_lat = 32;          // WAIT cycles until done is visible; 0 = never
    int mcnt = 0, dcnt = 0;
    logic [31:0] model_hi = '0, model_lo = '0;

    always #5 clk = ~clk;

    mult_div_ctrl #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .Reset(Reset), .OpStart(OpStart), .OpCode(OpCode),
        .A(A), .B(B), .OperandA(OperandA), .OperandB(OperandB),
        .MultIn(MultIn), .MultOut(MultOut), .MultHi(MultHi), .MultLo(MultLo),
        .DivIn(DivIn), .DivOut(DivOut), .DivHi(DivHi), .DivLo(DivLo),
        .Hi(Hi), .Lo(Lo), .Busy(Busy), .DivZero(DivZero), .Timeout(Timeout)
    );

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    // Returns {remainder, quotient} of a signed divide.
    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] x, y, q, r;
        if (b == 0) return 64'd0;
        x = a;
        y = b;
        q = x / y;
        r = x % y;
        return {r, q};
    endfunction

    // Behavioural units: done drops on start and rises unit_lat WAIT cycles later.
    always @(posedge clk) begin
        if (MultIn) begin
            MultOut <= 1'b0;
            mcnt <= (unit_lat == 0) ? 0 : unit_lat - 1;
            {MultHi, MultLo} <= smul(OperandA, OperandB);
        end else if (mcnt > 1) begin
            mcnt <= mcnt - 1;
        end else if (mcnt == 1) begin
            mcnt <= 0;
            MultOut <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (DivIn) begin
            DivOut <= 1'b0;
            dcnt <= (unit_lat == 0) ? 0 : unit_lat - 1;
            {DivHi, DivLo} <= sdiv(OperandA, OperandB);
        end else if (dcnt > 1) begin
            dcnt <= dcnt - 1;
        end else if (dcnt == 1) begin
            dcnt <= 0;
            DivOut <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_opa"}, 64'(OperandA), 64'd0);
        chk({tag, "_opb"}, 64'(OperandB), 64'd0);
        chk({tag, "_hi"}, 64'(Hi), 64'd0);
        chk({tag, "_lo"}, 64'(Lo), 64'd0);
        chk({tag, "_ctl"}, 64'({MultIn, DivIn, Busy, DivZero, Timeout}), 64'd0);
    endtask

    // Issue MTHI/MTLO at a negedge; the write is visible one cycle later.
    task automatic do_mt(input logic [1:0] op, input logic [31:0] a);
        OpStart = 1'b1; OpCode = op; A = a; B = $urandom;
        @(negedge clk);
        OpStart = 1'b0;
        if (op == 2'b10) model_hi = a; else model_lo = a;
        chk("mt_busy", 64'(Busy), 64'd0);
        chk("mt_hi", 64'(Hi), 64'(model_hi));
        chk("mt_lo", 64'(Lo), 64'(model_lo));
        $display("MT%s A=%08h -> Hi=%08h Lo=%08h", (op == 2'b10) ? "HI" : "LO", a, Hi, Lo);
    endtask

    // Issue MULT/DIV; optionally hold a pending MTHI request while busy.
    task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input bit hold, input logic [31:0] hold_val);
        int busy_cyc = 0, mp = 0, dp = 0, tp = 0, zp = 0, n = 0;
        bit is_div = (op == 2'b01);
        bit dz = is_div && (b == 0);
        bit to = !dz && (lat == 0 || lat > TIMEOUT);
        int exp_busy = dz ? 0 : (to ? 1 + TIMEOUT : lat + 2);
        logic [63:0] res = is_div ? sdiv(a, b) : smul(a, b);
        unit_lat = lat;
        OpStart = 1'b1; OpCode = op; A = a; B = b;
        @(negedge clk);
        if (hold) begin OpCode = 2'b10; A = hold_val; end
        else OpStart = 1'b0;
        forever begin
            mp += int'(MultIn); dp += int'(DivIn);
            tp += int'(Timeout); zp += int'(DivZero);
            if (!Busy || n >= 200) break;
            busy_cyc++; n++;
            @(negedge clk);
        end
        if (!dz && !to) begin
            model_hi = res[63:32];
            model_lo = res[31:0];
        end
        chk("busy_cycles", 64'(busy_cyc), 64'(exp_busy));
        chk("res_hi", 64'(Hi), 64'(model_hi));
        chk("res_lo", 64'(Lo), 64'(model_lo));
        if (!dz) begin
            chk("operand_a", 64'(OperandA), 64'(a));
            chk("operand_b", 64'(OperandB), 64'(b));
        end
        @(negedge clk);
        mp += int'(MultIn); dp += int'(DivIn);
        tp += int'(Timeout); zp += int'(DivZero);
        chk("mult_pulses", 64'(mp), 64'((!is_div) ? 1 : 0));
        chk("div_pulses", 64'(dp), 64'((is_div && !dz) ? 1 : 0));
        chk("timeout_pulses", 64'(tp), 64'(to ? 1 : 0));
        chk("divzero_pulses", 64'(zp), 64'(dz ? 1 : 0));
        if (hold) begin
            model_hi = hold_val;
            chk("held_mthi", 64'(Hi), 64'(model_hi));
            OpStart = 1'b0;
        end
        $display("%s A=%08h B=%08h lat=%0d busy=%0d to=%0d dz=%0d -> Hi=%08h Lo=%08h",
                 is_div ? "DIV " : "MULT", a, b, lat, busy_cyc, tp, zp, Hi, Lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          rlat;
        int          n;

        @(negedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        Reset = 1'b1;
        @(negedge clk);

        do_mt(2'b10, 32'h1234_5678);
        do_mt(2'b11, 32'h9ABC_DEF0);

        run_md(2'b00, 32'hFFFF_FFFD, 32'd7, 32, 1'b0, 32'd0);
        chk("mult_neg_hi", 64'(Hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg_lo", 64'(Lo), 64'h0000_0000_FFFF_FFEB);

        run_md(2'b01, 32'd100, 32'd7, 32, 1'b1, 32'hDEAD_BEEF);
        chk("div_lo_quot", 64'(Lo), 64'd14);

        run_md(2'b01, 32'd55, 32'd0, 32, 1'b0, 32'd0);

        run_md(2'b00, 32'd3, 32'd5, 0, 1'b0, 32'd0);
        do_mt(2'b11, 32'h0BAD_F00D);

        run_md(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, TIMEOUT, 1'b0, 32'd0);
        run_md(2'b01, 32'hFFFF_FF9C, 32'd9, TIMEOUT + 1, 1'b0, 32'd0);
        run_md(2'b01, 32'hFFFF_FF9C, 32'd9, 2, 1'b0, 32'd0);

        // Asynchronous reset in the middle of a multiply wait.
        unit_lat = 20;
        OpStart = 1'b1; OpCode = 2'b00; A = 32'd11; B = 32'd13;
        @(negedge clk);
        OpStart = 1'b0;
        repeat (8) @(negedge clk);
        #2 Reset = 1'b0;
        #1 chk_all_zero("async_reset");
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        Reset = 1'b1;
        n = 0;
        while (!MultOut && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("stale_done_seen", 64'(MultOut), 64'd1);
        repeat (3) @(negedge clk);
        chk("stale_done_hi", 64'(Hi), 64'd0);
        chk("stale_done_lo", 64'(Lo), 64'd0);
        chk("stale_done_busy", 64'(Busy), 64'd0);
        $display("RESET mid-wait -> Hi=%08h Lo=%08h Busy=%0b", Hi, Lo, Busy);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (rop == 2'b01 && $urandom_range(0, 5) == 0) rb = 32'd0;
            if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
            rlat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, 44));
            if (rop[1]) do_mt(rop, ra);
            else run_md(rop, ra, rb, rlat, 1'($urandom_range(0, 1)), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
